// File: rtl/ds1302_slave_model.sv
// ds1302_slave_model
//   Synthesizable responder for the DS1302 3-wire serial protocol (CE/SCLK/IO).
//   Holds the BCD clock/calendar, advances it once per second when the clock
//   is not halted, and answers single-byte (and optionally clock-burst)
//   read/write commands from a 3-wire master.
//
//   Optional feature macro: DS1302_SLAVE_BURST_EN
//     defined   : address 31 is clock burst (8 bytes sec..ctrl, reads wrap)
//     undefined : address 31 is ignored like any other unmapped address
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   ce      in   chip enable from master (asynchronous pin)
//   sclk    in   serial clock from master (asynchronous pin)
//   io_in   in   IO pin value
//   io_out  out  serial read data, LSB first
//   io_oe   out  IO output enable (tri-state built at the top level)
//   cal_bcd out  {year,day,month,date,hour,min,sec} live register image
module ds1302_slave_model #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        sclk,
  input  logic        io_in,
  output logic        io_out,
  output logic        io_oe,
  output logic [55:0] cal_bcd
);

  localparam int             PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_TC = PW'(CLK_HZ - 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_e;

  // ---------------- input synchronizers / edge detect ----------------
  logic [SYNC_STAGES-1:0] ce_sq, sclk_sq, io_sq;
  logic ce_prev_q, sclk_prev_q;
  logic ce_s, sclk_s, io_s, ce_rise, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_sq       <= '0;
      sclk_sq     <= '0;
      io_sq       <= '0;
      ce_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      ce_sq       <= {ce_sq[SYNC_STAGES-2:0], ce};
      sclk_sq     <= {sclk_sq[SYNC_STAGES-2:0], sclk};
      io_sq       <= {io_sq[SYNC_STAGES-2:0], io_in};
      ce_prev_q   <= ce_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign ce_s      = ce_sq[SYNC_STAGES-1];
  assign sclk_s    = sclk_sq[SYNC_STAGES-1];
  assign io_s      = io_sq[SYNC_STAGES-1];
  assign ce_rise   = ce_s & ~ce_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // ---------------- registers ----------------
  logic [7:0] sec_q, min_q, hour_q, date_q, month_q, day_q, year_q;
  logic [7:0] sec_d, min_d, hour_d, date_d, month_d, day_d, year_d;
  logic       wp_q;
  logic [PW-1:0] presc_q;
  logic [7:0][7:0] live;

  assign live    = {wp_q, 7'b0, year_q, day_q, month_q, date_q, hour_q, min_q, sec_q};
  assign cal_bcd = {year_q, day_q, month_q, date_q, hour_q, min_q, sec_q};

  // ---------------- serial FSM ----------------
  state_e          state_q;
  logic [6:0]      sr_q;
  logic [3:0]      bit_q;
  logic [2:0]      idx_q;
  logic            burst_q;
  logic [7:0][7:0] shadow_q;
  logic            wr_vld_q;
  logic [2:0]      wr_idx_q;
  logic [7:0]      wr_data_q;

  logic [7:0] shift_byte;
  logic [4:0] cmd_addr;
  logic       is_burst, cmd_ok;
  logic [2:0] idx_nxt;

  // Byte arrives LSB first, so the 8th sampled bit lands in bit 7.
  assign shift_byte = {io_s, sr_q};
  assign cmd_addr   = shift_byte[5:1];
  assign idx_nxt    = idx_q + 3'd1;
`ifdef DS1302_SLAVE_BURST_EN
  assign is_burst   = (cmd_addr == 5'd31);
`else
  assign is_burst   = 1'b0;
`endif
  assign cmd_ok     = shift_byte[7] & ~shift_byte[6] & ((cmd_addr < 5'd8) | is_burst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      burst_q   <= 1'b0;
      shadow_q  <= '0;
      wr_vld_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      io_oe     <= 1'b0;
      io_out    <= 1'b0;
    end else begin
      wr_vld_q <= 1'b0;
      // ce low aborts everything; a partial write byte never reaches wr_vld_q.
      if (!ce_s) begin
        state_q <= IDLE;
        io_oe   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ce_rise) begin
            shadow_q <= live;
            bit_q    <= '0;
            state_q  <= CMD;
          end
          CMD: if (sclk_rise) begin
            sr_q  <= shift_byte[7:1];
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              bit_q   <= '0;
              burst_q <= is_burst;
              idx_q   <= is_burst ? 3'd0 : cmd_addr[2:0];
              if (!cmd_ok)           state_q <= IGNORE;
              else if (shift_byte[0]) state_q <= RDATA;
              else                    state_q <= WDATA;
            end
          end
          WDATA: if (sclk_rise) begin
            sr_q  <= shift_byte[7:1];
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              wr_vld_q  <= 1'b1;
              wr_idx_q  <= idx_q;
              wr_data_q <= shift_byte;
              bit_q     <= '0;
              idx_q     <= idx_nxt;
              if (!burst_q || idx_q == 3'd7) state_q <= IGNORE;
            end
          end
          RDATA: if (sclk_fall) begin
            // bit_q==8: the whole byte has been driven and sampled.
            if (bit_q == 4'd8) begin
              if (burst_q) begin
                io_out <= shadow_q[idx_nxt][0];
                idx_q  <= idx_nxt;
                bit_q  <= 4'd1;
              end else begin
                io_oe   <= 1'b0;
                state_q <= IGNORE;
              end
            end else begin
              io_oe  <= 1'b1;
              io_out <= shadow_q[idx_q][bit_q[2:0]];
              bit_q  <= bit_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- timekeeping ----------------
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'h9) return {v[7:4] + 4'd1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic tick, c_sec, c_min, c_hr, c_mon, c_yr, leap, wr_ok;
  logic [7:0] mdays;

  always_comb begin
    // Tens parity is year_q[4]; leap years are x0/x4/x8 for even tens, x2/x6 for odd.
    leap = (~year_q[4] & (year_q[3:0] inside {4'h0, 4'h4, 4'h8})) |
           ( year_q[4] & (year_q[3:0] inside {4'h2, 4'h6}));
    case (month_q)
      8'h02:                      mdays = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: mdays = 8'h30;
      default:                    mdays = 8'h31;
    endcase
    tick    = ~sec_q[7] && (presc_q == PRESC_TC);
    c_sec   = tick  && (sec_q   >= 8'h59);
    c_min   = c_sec && (min_q   >= 8'h59);
    c_hr    = c_min && (hour_q  >= 8'h23);
    c_mon   = c_hr  && (date_q  >= mdays);
    c_yr    = c_mon && (month_q >= 8'h12);
    sec_d   = !tick  ? sec_q   : (c_sec ? 8'h00 : bcd_inc(sec_q));
    min_d   = !c_sec ? min_q   : (c_min ? 8'h00 : bcd_inc(min_q));
    hour_d  = !c_min ? hour_q  : (c_hr  ? 8'h00 : bcd_inc(hour_q));
    date_d  = !c_hr  ? date_q  : (c_mon ? 8'h01 : bcd_inc(date_q));
    day_d   = !c_hr  ? day_q   : ((day_q >= 8'h07) ? 8'h01 : bcd_inc(day_q));
    month_d = !c_mon ? month_q : (c_yr  ? 8'h01 : bcd_inc(month_q));
    year_d  = !c_yr  ? year_q  : ((year_q >= 8'h99) ? 8'h00 : bcd_inc(year_q));
    wr_ok   = wr_vld_q && ((wr_idx_q == 3'd7) || !wp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q   <= 8'h80;
      min_q   <= 8'h00;
      hour_q  <= 8'h00;
      date_q  <= 8'h01;
      month_q <= 8'h01;
      day_q   <= 8'h01;
      year_q  <= 8'h00;
      wp_q    <= 1'b0;
      presc_q <= '0;
    end else begin
      presc_q <= sec_q[7] ? presc_q : (tick ? '0 : presc_q + PW'(1));
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      date_q  <= date_d;
      month_q <= month_d;
      day_q   <= day_d;
      year_q  <= year_d;
      // A committed write overrides only its own register's tick result.
      if (wr_ok) begin
        case (wr_idx_q)
          3'd0: begin
            sec_q   <= wr_data_q;
            presc_q <= '0;
          end
          3'd1:    min_q   <= wr_data_q;
          3'd2:    hour_q  <= {1'b0, wr_data_q[6:0]};
          3'd3:    date_q  <= wr_data_q;
          3'd4:    month_q <= wr_data_q;
          3'd5:    day_q   <= wr_data_q;
          3'd6:    year_q  <= wr_data_q;
          default: wp_q    <= wr_data_q[7];
        endcase
      end
    end
  end

endmodule
